// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 16-bit data memory.
// One access at a time; optional lock keeps ownership for atomic sequences.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: a port holds req with a stable payload until it sees its
    // 1-cycle gnt; a read then returns data with a 1-cycle rvalid one cycle later.
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    logic          last;
    logic          locked;
    logic          owner;
    logic          cur_we;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          own_req;
    logic          own_lock;
    logic          elig0;
    logic          elig1;
    logic          any_elig;
    logic          winner;
    logic          win_we;
    logic          win_lock;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    always_comb begin
        own_req   = owner ? p1_req  : p0_req;
        own_lock  = owner ? p1_lock : p0_lock;
        elig0     = p0_req && (!locked || !owner);
        elig1     = p1_req && (!locked ||  owner);
        any_elig  = elig0 || elig1;
        // On a tie the port that did not win last time goes first.
        winner    = (elig0 && elig1) ? ~last : elig1;
        win_we    = winner ? p1_we    : p0_we;
        win_lock  = winner ? p1_lock  : p0_lock;
        win_addr  = winner ? p1_addr  : p0_addr;
        win_wdata = winner ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            locked    <= 1'b0;
            owner     <= 1'b0;
            cur_we    <= 1'b0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state     <= ISSUE;
                        last      <= winner;
                        owner     <= winner;
                        locked    <= win_lock;
                        cur_we    <= win_we;
                        p0_gnt    <= ~winner;
                        p1_gnt    <= winner;
                        mem_we    <= win_we;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                    end else if (locked && !own_req && !own_lock) begin
                        locked <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (cur_we) begin
                        state <= IDLE;
                    end else begin
                        state     <= RESP;
                        p0_rvalid <= ~owner;
                        p1_rvalid <= owner;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (owner) rdata1_q <= mem_rdata;
                    else       rdata0_q <= mem_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The rvalid cycle forwards memory data directly; the register holds it afterwards.
    assign p0_rdata  = (state == RESP && !owner) ? mem_rdata : rdata0_q;
    assign p1_rdata  = (state == RESP &&  owner) ? mem_rdata : rdata1_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level schedule model plus directed vectors.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 'h20) return 16'h1234;
    return 16'(i * 7 + 3);
  endfunction

  // memory: data appears one cycle after the read command
  logic [DW-1:0] tb_mem [256];
  bit            mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr[7:0]];
    end
  end

  // model: an access decided in free cycle T shows gnt at T+1, rvalid at T+2
  typedef struct packed {
    logic          g0, g1, v0, v1, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t          sched [int];
  exp_t          cur, e;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [256];
  bit            ref_ready = 1'b0;
  int            cyc = 0;
  int            free_at = 0;
  logic          m_last = 1'b1, m_locked = 1'b0, m_owner = 1'b0;
  logic          m_r0, m_r1, m_w;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;
  logic          e_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!ref_ready) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_ready = 1'b1;
      end
      sched.delete();
      exp_q.delete();
      free_at  = cyc;
      m_last   = 1'b1;
      m_locked = 1'b0;
      m_owner  = 1'b0;
      cur      = '0;
      e_addr   = '0;
      e_wdata  = '0;
      e_rd0    = '0;
      e_rd1    = '0;
      e_busy   = 1'b0;
    end else begin
      if (cyc >= free_at) begin
        m_r0 = p0_req && (!m_locked || !m_owner);
        m_r1 = p1_req && (!m_locked ||  m_owner);
        if (m_r0 || m_r1) begin
          m_w     = (m_r0 && m_r1) ? !m_last : m_r1;
          e       = '0;
          e.g0    = !m_w;
          e.g1    = m_w;
          e.we    = m_w ? p1_we : p0_we;
          e.addr  = m_w ? p1_addr : p0_addr;
          e.wdata = m_w ? p1_wdata : p0_wdata;
          sched[cyc + 1] = e;
          m_last   = m_w;
          m_owner  = m_w;
          m_locked = m_w ? p1_lock : p0_lock;
          if (e.we) begin
            ref_mem[e.addr[7:0]] = e.wdata;
            free_at = cyc + 2;
          end else begin
            exp_q.push_back(ref_mem[e.addr[7:0]]);
            e    = '0;
            e.v0 = !m_w;
            e.v1 = m_w;
            sched[cyc + 2] = e;
            free_at = cyc + 3;
          end
        end else if (m_locked && !(m_owner ? p1_req : p0_req) && !(m_owner ? p1_lock : p0_lock)) begin
          m_locked = 1'b0;
        end
      end
      cyc = cyc + 1;
      cur = '0;
      if (sched.exists(cyc)) begin
        cur = sched[cyc];
        sched.delete(cyc);
      end
      if (cur.g0 || cur.g1) begin
        e_addr  = cur.addr;
        e_wdata = cur.wdata;
      end
      if (cur.v0 && exp_q.size() > 0) e_rd0 = exp_q.pop_front();
      if (cur.v1 && exp_q.size() > 0) e_rd1 = exp_q.pop_front();
      e_busy = (cyc < free_at);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every out-of-reset cycle against the model
  int gq [$];
  always @(negedge clk) begin
    if (rst_n) begin
      chk("p0_gnt",    p0_gnt,    cur.g0);
      chk("p1_gnt",    p1_gnt,    cur.g1);
      chk("p0_rvalid", p0_rvalid, cur.v0);
      chk("p1_rvalid", p1_rvalid, cur.v1);
      chk("mem_we",    mem_we,    cur.we);
      chk("mem_addr",  mem_addr,  e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("p0_rdata",  p0_rdata,  e_rd0);
      chk("p1_rdata",  p1_rdata,  e_rd1);
      chk("busy",      busy,      e_busy);
      if (p0_gnt) gq.push_back(0);
      if (p1_gnt) gq.push_back(1);
    end
  end

  // drivers
  task automatic access(input int port, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit got = 1'b0;
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_lock = lock; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_lock = lock; p1_addr = addr; p1_wdata = wdata;
    end
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = (port == 0) ? p0_gnt : p1_gnt;
    end
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gnt_timeout port %0d: no grant, required one within 30 cycles", port);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_order(input string nm, input int exp_ord [$]);
    chk({nm, "_count"}, gq.size(), exp_ord.size());
    for (int i = 0; i < exp_ord.size() && i < gq.size(); i++)
      chk(nm, gq[i], exp_ord[i]);
  endtask

  initial begin
    int ord [$];
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",   busy, 0);
    chk("rst_gnt",    {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_addr",   mem_addr, 0);
    chk("rst_wdata",  mem_wdata, 0);
    chk("rst_rdata",  {p0_rdata, p1_rdata}, 0);
    chk("rst_state",  dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single write from port 0
    p0_req = 1'b1; p0_we = 1'b1; p0_lock = 1'b0; p0_addr = 16'h0010; p0_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_gnt",   p0_gnt, 1);
    chk("wr_we",    mem_we, 1);
    chk("wr_addr",  mem_addr, 16'h0010);
    chk("wr_wdata", mem_wdata, 16'hBEEF);
    p0_req = 1'b0;
    @(negedge clk);
    chk("wr_idle",  busy, 0);
    chk("wr_we_off", mem_we, 0);
    chk("wr_mem",   tb_mem[8'h10], 16'hBEEF);

    // read from port 1
    p1_req = 1'b1; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = 16'h0020; p1_wdata = 16'h0;
    @(negedge clk);
    chk("rd_gnt",   p1_gnt, 1);
    chk("rd_we",    mem_we, 0);
    chk("rd_addr",  mem_addr, 16'h0020);
    p1_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", p1_rvalid, 1);
    chk("rd_data",   p1_rdata, 16'h1234);
    @(negedge clk);
    chk("rd_rvalid_off", p1_rvalid, 0);
    chk("rd_hold",   p1_rdata, 16'h1234);
    chk("rd_idle",   busy, 0);

    // contention after reset alternates starting with port 0
    do_reset();
    gq.delete();
    fork
      begin access(0, 1'b1, 1'b0, 16'h0100, 16'h0001); access(0, 1'b1, 1'b0, 16'h0102, 16'h0003); end
      begin access(1, 1'b1, 1'b0, 16'h0101, 16'h0002); access(1, 1'b1, 1'b0, 16'h0103, 16'h0004); end
    join
    repeat (3) @(negedge clk);
    ord = '{0, 1, 0, 1};
    chk_order("rr_order", ord);

    // lock: port 1 keeps ownership for three writes while port 0 waits
    gq.delete();
    fork
      begin
        access(1, 1'b1, 1'b1, 16'h0030, 16'hA001);
        access(1, 1'b1, 1'b1, 16'h0031, 16'hA002);
        access(1, 1'b1, 1'b0, 16'h0032, 16'hA003);
      end
      begin
        repeat (3) @(negedge clk);
        access(0, 1'b1, 1'b0, 16'h0040, 16'hB001);
      end
    join
    repeat (3) @(negedge clk);
    ord = '{1, 1, 1, 0};
    chk_order("lock_order", ord);

    // reset during the ISSUE cycle of a read
    p0_req = 1'b1; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = 16'h0020;
    @(negedge clk);
    chk("mid_gnt", p0_gnt, 1);
    #2;
    rst_n  = 1'b0;
    p0_req = 1'b0;
    #1;
    chk("mid_gnt_off", p0_gnt, 0);
    chk("mid_busy",    busy, 0);
    chk("mid_we",      mem_we, 0);
    chk("mid_addr",    mem_addr, 0);
    chk("mid_rvalid",  p0_rvalid, 0);
    @(negedge clk);
    chk("mid_rvalid2", p0_rvalid, 0);
    rst_n = 1'b1;
    gq.delete();
    repeat (3) @(negedge clk);
    fork
      access(0, 1'b1, 1'b0, 16'h0050, 16'hC001);
      access(1, 1'b1, 1'b0, 16'h0051, 16'hC002);
    join
    repeat (3) @(negedge clk);
    ord = '{0, 1};
    chk_order("post_rst_order", ord);

    // port 0 request pulsed while port 1 read is in RESP
    gq.delete();
    fork
      access(1, 1'b0, 1'b0, 16'h0020, 16'h0000);
      begin
        repeat (2) @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_lock = 1'b0; p0_addr = 16'h0077; p0_wdata = 16'hDEAD;
        @(negedge clk);
        p0_req = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    ord = '{1};
    chk_order("wd_order", ord);
    chk("wd_rdata", p1_rdata, 16'h1234);
    chk("wd_mem",   tb_mem[8'h77], init_val('h77));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
